// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX forwarding / D-stage hazard unit.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned FWD_SEL_RF = 0;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

    function automatic int unsigned fwd_sel_w(input int unsigned num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for multi-cycle results that cannot be forwarded.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int unsigned REG_AW  = REG_AW_DEF,
    parameter  int unsigned MAX_OUT = 4,
    localparam int unsigned NREG    = 2**REG_AW,
    localparam int unsigned CW      = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              done,
    input  logic [REG_AW-1:0] done_rd,
    output logic [NREG-1:0]   busy_vec,
    output logic [CW-1:0]     out_cnt,
    output logic              err_spurious
);

    logic            done_ok;
    logic [NREG-1:0] busy_n;

    // A completion only counts against a tracked op; anything else is spurious.
    assign done_ok = done && (done_rd != '0) && busy_vec[done_rd] && (out_cnt != '0);

    always_comb begin
        busy_n = busy_vec;
        if (done_ok) busy_n[done_rd] = 1'b0;
        if (issue)   busy_n[issue_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_vec     <= '0;
            out_cnt      <= '0;
            err_spurious <= 1'b0;
        end else begin
            busy_vec <= busy_n;
            if (issue && !done_ok)
                out_cnt <= out_cnt + CW'(1);
            else if (!issue && done_ok)
                out_cnt <= out_cnt - CW'(1);
            if (done && !done_ok)
                err_spurious <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// EX-stage operand forwarding plus D-stage load-use / multi-cycle hazard detection.
module hazard_fwd_scoreboard
    import hazard_pkg::*;
#(
    parameter  int unsigned REG_AW  = REG_AW_DEF,
    parameter  int unsigned NUM_SRC = 2,
    parameter  int unsigned NUM_FWD = 2,
    parameter  int unsigned MAX_OUT = 4,
    parameter  int unsigned CNT_W   = 32,
    localparam int unsigned NREG    = 2**REG_AW,
    localparam int unsigned SW      = fwd_sel_w(NUM_FWD),
    localparam int unsigned CW      = $clog2(MAX_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] src_e,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_SRC*REG_AW-1:0] src_d,
    input  logic [NUM_SRC-1:0]        src_used_d,
    input  logic [REG_AW-1:0]         dst_d,
    input  logic                      dst_we_d,
    input  logic                      long_d,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic                      regwrite_e,
    input  logic                      load_e,
    input  logic                      long_issue_e,
    input  logic                      flush_e,
    input  logic                      long_done,
    input  logic [REG_AW-1:0]         long_rd,
    output logic [NUM_SRC*SW-1:0]     fwd_sel,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      bubble_e,
    output logic [NREG-1:0]           busy_vec,
    output logic [CW-1:0]             out_cnt,
    output logic                      err_spurious,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic [SW-1:0] sel;
    logic          found;
    logic          match_e;
    logic          raw_long;
    logic          issue;
    logic          load_use;
    logic          inflight;
    logic          waw;
    logic          full;
    logic          hazard;

    // Scan stages youngest-first; the first hit locks the selection.
    always_comb begin
        fwd_sel = '0;
        sel     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sel   = SW'(FWD_SEL_RF);
            found = 1'b0;
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (!found && fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                    (fwd_rd[k*REG_AW +: REG_AW] == src_e[i*REG_AW +: REG_AW])) begin
                    sel   = SW'(k + 1);
                    found = 1'b1;
                end
            end
            fwd_sel[i*SW +: SW] = sel;
        end
    end

    always_comb begin
        match_e  = 1'b0;
        raw_long = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_used_d[i]) begin
                if (src_d[i*REG_AW +: REG_AW] == rd_e)        match_e  = 1'b1;
                if (busy_vec[src_d[i*REG_AW +: REG_AW]])      raw_long = 1'b1;
            end
        end
    end

    assign issue    = long_issue_e && !flush_e && (rd_e != '0);
    assign load_use = regwrite_e && load_e && !flush_e && (rd_e != '0) && match_e;
    assign inflight = issue && match_e;
    assign waw      = dst_we_d && (dst_d != '0) && busy_vec[dst_d];
    // An issue landing this cycle already consumes the last free slot.
    assign full     = long_d && ((out_cnt == CW'(MAX_OUT)) ||
                                 ((out_cnt == CW'(MAX_OUT - 1)) && issue));
    assign hazard   = rst_n && (load_use || raw_long || inflight || waw || full);

    assign stall_f  = hazard;
    assign stall_d  = hazard;
    assign bubble_e = hazard;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_d && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    hazard_scoreboard #(
        .REG_AW  (REG_AW),
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue        (issue),
        .issue_rd     (rd_e),
        .done         (long_done),
        .done_rd      (long_rd),
        .busy_vec     (busy_vec),
        .out_cnt      (out_cnt),
        .err_spurious (err_spurious)
    );

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench: expectations queued with each stimulus step, popped at the sample point.
module tb_hazard_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  src_e;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic [9:0]  src_d;
    logic [1:0]  src_used_d;
    logic [4:0]  dst_d;
    logic        dst_we_d;
    logic        long_d;
    logic [4:0]  rd_e;
    logic        regwrite_e;
    logic        load_e;
    logic        long_issue_e;
    logic        flush_e;
    logic        long_done;
    logic [4:0]  long_rd;
    logic [3:0]  fwd_sel;
    logic        stall_f;
    logic        stall_d;
    logic        bubble_e;
    logic [31:0] busy_vec;
    logic [2:0]  out_cnt;
    logic        err_spurious;
    logic [31:0] stall_cnt;

    int unsigned checks    = 0;
    int unsigned errors    = 0;
    int unsigned exp_stall = 0;
    logic        exp_h     = 1'b0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_fwd_scoreboard #(
        .REG_AW  (5),
        .NUM_SRC (2),
        .NUM_FWD (2),
        .MAX_OUT (4),
        .CNT_W   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_e        (src_e),
        .fwd_we       (fwd_we),
        .fwd_rd       (fwd_rd),
        .src_d        (src_d),
        .src_used_d   (src_used_d),
        .dst_d        (dst_d),
        .dst_we_d     (dst_we_d),
        .long_d       (long_d),
        .rd_e         (rd_e),
        .regwrite_e   (regwrite_e),
        .load_e       (load_e),
        .long_issue_e (long_issue_e),
        .flush_e      (flush_e),
        .long_done    (long_done),
        .long_rd      (long_rd),
        .fwd_sel      (fwd_sel),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .bubble_e     (bubble_e),
        .busy_vec     (busy_vec),
        .out_cnt      (out_cnt),
        .err_spurious (err_spurious),
        .stall_cnt    (stall_cnt)
    );

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_q.push_back('{tag, v});
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_empty: observed %0h expected <entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_h(input logic h);
        exp_h = h;
        expect_val("stall_f", 64'(h));  check(64'(stall_f));
        expect_val("stall_d", 64'(h));  check(64'(stall_d));
        expect_val("bubble_e", 64'(h)); check(64'(bubble_e));
    endtask

    task automatic chk_state(input logic [31:0] busy, input logic [2:0] cnt, input logic err);
        expect_val("busy_vec", 64'(busy));    check(64'(busy_vec));
        expect_val("out_cnt", 64'(cnt));      check(64'(out_cnt));
        expect_val("err_spurious", 64'(err)); check(64'(err_spurious));
    endtask

    task automatic chk_fwd(input logic [3:0] v);
        expect_val("fwd_sel", 64'(v));
        check(64'(fwd_sel));
    endtask

    task automatic chk_cnt();
        expect_val("stall_cnt", 64'(exp_stall));
        check(64'(stall_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n)     exp_stall = 0;
        else if (exp_h) exp_stall++;
        #1;
    endtask

    task automatic idle();
        src_e = '0; fwd_we = '0; fwd_rd = '0; src_d = '0; src_used_d = '0;
        dst_d = '0; dst_we_d = 1'b0; long_d = 1'b0; rd_e = '0; regwrite_e = 1'b0;
        load_e = 1'b0; long_issue_e = 1'b0; flush_e = 1'b0; long_done = 1'b0; long_rd = '0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        long_issue_e = 1'b1; regwrite_e = 1'b1; rd_e = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick(); tick();

        // Hazard inputs active while in reset: stalls must stay low
        regwrite_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; src_d = {5'd0, 5'd7}; src_used_d = 2'b01;
        #1 chk_h(1'b0);
        tick();
        chk_state(32'h0, 3'd0, 1'b0);
        chk_cnt();

        rst_n = 1'b1;
        idle();
        #1 chk_h(1'b0);

        // Forwarding priority
        src_e = {5'd8, 5'd5}; fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5};
        #1 chk_fwd(4'h1);
        fwd_rd = {5'd5, 5'd0};
        #1 chk_fwd(4'h2);
        fwd_rd = {5'd8, 5'd5};
        #1 chk_fwd(4'h9);
        fwd_we = 2'b10;
        #1 chk_fwd(4'h8);
        src_e = '0; fwd_we = 2'b11; fwd_rd = '0;
        #1 chk_fwd(4'h0);
        chk_h(1'b0);
        tick();

        // Load-use
        idle();
        regwrite_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; src_d = {5'd0, 5'd7}; src_used_d = 2'b01;
        #1 chk_h(1'b1);
        tick();
        src_used_d = 2'b00;
        #1 chk_h(1'b0);
        src_used_d = 2'b01; flush_e = 1'b1;
        #1 chk_h(1'b0);
        flush_e = 1'b0; src_d = {5'd7, 5'd3}; src_used_d = 2'b10;
        #1 chk_h(1'b1);
        tick();
        idle();
        #1 chk_h(1'b0);
        chk_cnt();
        tick();

        // Long op rd=9 with dependent D instruction
        issue_long(5'd9); src_d = {5'd0, 5'd9}; src_used_d = 2'b01;
        #1 chk_h(1'b1);
        tick();
        chk_state(32'h0000_0200, 3'd1, 1'b0);
        idle(); src_d = {5'd0, 5'd9}; src_used_d = 2'b01;
        #1 chk_h(1'b1);
        tick();
        long_done = 1'b1; long_rd = 5'd9;
        #1 chk_h(1'b1);
        tick();
        chk_state(32'h0, 3'd0, 1'b0);
        long_done = 1'b0;
        #1 chk_h(1'b0);
        chk_cnt();
        tick();

        // Fill the multi-cycle unit
        idle(); issue_long(5'd10);
        #1 chk_h(1'b0);
        tick();
        issue_long(5'd11);
        #1 chk_h(1'b0);
        tick();
        issue_long(5'd12);
        #1 chk_h(1'b0);
        tick();
        issue_long(5'd6); long_d = 1'b1;
        #1 chk_h(1'b1);
        tick();
        chk_state(32'h0000_1C40, 3'd4, 1'b0);
        idle(); long_d = 1'b1;
        #1 chk_h(1'b1);
        tick();
        long_d = 1'b0;
        #1 chk_h(1'b0);
        dst_we_d = 1'b1; dst_d = 5'd12;
        #1 chk_h(1'b1);
        tick();
        dst_d = 5'd13;
        #1 chk_h(1'b0);
        tick();

        // Completion and issue in the same cycle
        idle(); long_done = 1'b1; long_rd = 5'd10; issue_long(5'd14);
        #1 chk_h(1'b0);
        tick();
        chk_state(32'h0000_5840, 3'd4, 1'b0);
        idle(); long_done = 1'b1; long_rd = 5'd6; issue_long(5'd6);
        #1 chk_h(1'b0);
        tick();
        chk_state(32'h0000_5840, 3'd4, 1'b0);

        // Flushed issue leaves state untouched
        idle(); issue_long(5'd20); flush_e = 1'b1;
        #1 chk_h(1'b0);
        tick();
        chk_state(32'h0000_5840, 3'd4, 1'b0);

        // Spurious completion
        idle(); long_done = 1'b1; long_rd = 5'd3;
        #1 chk_h(1'b0);
        tick();
        chk_state(32'h0000_5840, 3'd4, 1'b1);
        idle();
        #1 chk_h(1'b0);
        chk_cnt();

        // Reset mid-operation
        rst_n = 1'b0;
        tick();
        chk_state(32'h0, 3'd0, 1'b0);
        chk_cnt();
        rst_n = 1'b1;
        long_done = 1'b1; long_rd = 5'd12;
        #1 chk_h(1'b0);
        tick();
        chk_state(32'h0, 3'd0, 1'b1);
        idle();
        tick();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
